cr_huf_comp_ism_catcher_mc: RTL



---
 rtl/cr_huf_comp_ism_catcher_mc.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/cr_huf_comp_ism_catcher_mc.sv
// Multi-channel ISM symbol-depth catcher: round-robin capture of
// per-channel Huffman depth tables, packed into tagged ISM beats.
module cr_huf_comp_ism_catcher_mc #(
  parameter int NUM_CH               = 2,
  parameter int DAT_WIDTH            = 10,
  parameter int MAX_NUM_SYM_USED     = 576,
  parameter int CODELENGTH_WIDTH     = 5,
  parameter int ISM_CODELENGTH_WIDTH = 8,
  parameter int ISM_DATA_WIDTH       = 64,
  parameter int SEQID_WIDTH          = 6,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         ch_req,
  input  logic [NUM_CH*MAX_NUM_SYM_USED*CODELENGTH_WIDTH-1:0]
                                    ch_sym_dpth,
  input  logic [NUM_CH-1:0]         ch_zero_symbols,
  input  logic [NUM_CH-1:0]         ch_build_error,
  input  logic [NUM_CH*SEQID_WIDTH-1:0] ch_seq_id,
  output logic [NUM_CH-1:0]         ch_ack,
  input  logic                      sw_ism_on,
  input  logic                      ism_rdy,
  output logic                      ism_not_ready,
  output logic                      rd_vld,
  output logic [ISM_DATA_WIDTH-1:0] rd_data,
  output logic                      rd_eob,
  output logic                      rd_no_sym,
  output logic                      rd_build_error,
  output logic [7:0]                rd_seq_id,
  output logic [CH_W-1:0]           rd_ch_id,
  output logic [DAT_WIDTH-1:0]      rd_beat_idx
);

  localparam int MAX   = MAX_NUM_SYM_USED;
  localparam int CW    = CODELENGTH_WIDTH;
  localparam int ICW   = ISM_CODELENGTH_WIDTH;
  localparam int LANES = ISM_DATA_WIDTH / ICW;
  localparam int SI    = (MAX > 1) ? $clog2(MAX) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, RDY, WR} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]          dep [NUM_CH][MAX];
  logic [SEQID_WIDTH-1:0] sid [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign sid[c] = ch_seq_id[c*SEQID_WIDTH +: SEQID_WIDTH];
    for (genvar k = 0; k < MAX; k++) begin : g_sym
      assign dep[c][k] = ch_sym_dpth[(c*MAX+k)*CW +: CW];
    end
  end

  logic [CH_W-1:0]      g, g_nxt;
  logic [CH_W-1:0]      last, last_nxt;
  logic [DAT_WIDTH-1:0] ptr, ptr_nxt;
  logic [DAT_WIDTH-1:0] bidx, bidx_nxt;
  logic                 zs, zs_nxt;
  logic                 be, be_nxt;

  logic                      vld_d, eob_d;
  logic                      nosym_d, err_d;
  logic [ISM_DATA_WIDTH-1:0] data_d;
  logic [7:0]                seq_d;
  logic [CH_W-1:0]           chid_d;
  logic [DAT_WIDTH-1:0]      idx_d;
  logic [NUM_CH-1:0]         ack_d;

  logic [NUM_CH-1:0] req_m;
  logic [CH_W-1:0]   pick;
  int                best;
  int                d;

  // The retiring channel is masked so it cannot be regranted at once
  assign req_m = ch_req & ~ch_ack;

  always_comb begin
    pick = last;
    best = NUM_CH;
    d    = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      d = (c + 2*NUM_CH - 1 - int'(last)) % NUM_CH;
      if (req_m[c] && d < best) begin
        best = d;
        pick = CH_W'(c);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    g_nxt     = g;
    last_nxt  = last;
    ptr_nxt   = ptr;
    bidx_nxt  = bidx;
    zs_nxt    = zs;
    be_nxt    = be;
    vld_d     = 1'b0;
    eob_d     = 1'b0;
    nosym_d   = 1'b0;
    err_d     = 1'b0;
    data_d    = '0;
    seq_d     = '0;
    chid_d    = '0;
    idx_d     = '0;
    ack_d     = '0;
    unique case (state)
      IDLE: begin
        if (best < NUM_CH) begin
          g_nxt     = pick;
          last_nxt  = pick;
          ptr_nxt   = '0;
          bidx_nxt  = '0;
          zs_nxt    = 1'b0;
          be_nxt    = 1'b0;
          state_nxt = sw_ism_on ? RDY : GRANT;
        end
      end
      GRANT: begin
        ack_d[g]  = 1'b1;
        state_nxt = IDLE;
      end
      RDY: begin
        zs_nxt = zs | ch_zero_symbols[g];
        be_nxt = be | ch_build_error[g];
        if (ism_rdy) begin
          if (zs_nxt || be_nxt) begin
            vld_d     = 1'b1;
            eob_d     = 1'b1;
            nosym_d   = zs_nxt;
            err_d     = be_nxt;
            seq_d     = 8'(sid[g]);
            chid_d    = g;
            ack_d[g]  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = WR;
          end
        end
      end
      WR: begin
        if (ism_rdy) begin
          vld_d  = 1'b1;
          chid_d = g;
          idx_d  = bidx;
          for (int i = 0; i < LANES; i++) begin
            if (int'(ptr) + i < MAX) begin
              data_d[i*ICW +: ICW] =
                ICW'(dep[g][SI'(int'(ptr) + i)]);
            end
          end
          bidx_nxt = bidx + 1'b1;
          ptr_nxt  = ptr + DAT_WIDTH'(LANES);
          if (int'(ptr) + LANES >= MAX) begin
            eob_d     = 1'b1;
            nosym_d   = zs | ch_zero_symbols[g];
            err_d     = be | ch_build_error[g];
            seq_d     = 8'(sid[g]);
            ack_d[g]  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      g              <= '0;
      last           <= CH_W'(NUM_CH - 1);
      ptr            <= '0;
      bidx           <= '0;
      zs             <= 1'b0;
      be             <= 1'b0;
      ch_ack         <= '0;
      ism_not_ready  <= 1'b0;
      rd_vld         <= 1'b0;
      rd_data        <= '0;
      rd_eob         <= 1'b0;
      rd_no_sym      <= 1'b0;
      rd_build_error <= 1'b0;
      rd_seq_id      <= '0;
      rd_ch_id       <= '0;
      rd_beat_idx    <= '0;
    end else begin
      state          <= state_nxt;
      g              <= g_nxt;
      last           <= last_nxt;
      ptr            <= ptr_nxt;
      bidx           <= bidx_nxt;
      zs             <= zs_nxt;
      be             <= be_nxt;
      ch_ack         <= ack_d;
      ism_not_ready  <= (state_nxt != IDLE);
      rd_vld         <= vld_d;
      rd_data        <= data_d;
      rd_eob         <= eob_d;
      rd_no_sym      <= nosym_d;
      rd_build_error <= err_d;
      rd_seq_id      <= seq_d;
      rd_ch_id       <= chid_d;
      rd_beat_idx    <= idx_d;
    end
  end

endmodule
